// File: rtl/epmp_pkg.sv
// Shared definitions for the EPMP bus transfer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package epmp_pkg;

    // Default bus data width.
    localparam int W_DEFAULT = 8;

    // Transfer sequencer states. A bus transfer walks DRIVE -> SAMPLE -> WRITE;
    // an immediate transfer jumps straight from IDLE to WRITE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

endpackage

// File: rtl/epmp_bus_xfer.sv
// Register-transfer sequencer: enables one source onto the internal bus, captures it, strobes one destination.
// Latency: acceptance edge to load_en high is 3 cycles for a bus transfer, 1 cycle for an immediate transfer.
// Backpressure: req_ready is high only in IDLE; requests arriving while busy are held off, not queued.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_src, req_dst, req_imm_en, req_imm ride with it
//   out_en [N_SRC]                one-hot source output enable onto the internal bus
//   ibh_in [W]                    internal bus value from the enabled source
//   d_out [W], load_en [N_DST]    destination data and one-hot load strobe
//   done                          one-cycle pulse in the WRITE cycle
//   debug_latch [W]               holding latch contents
module epmp_bus_xfer
    import epmp_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int N_DST = 8,
    parameter int W     = W_DEFAULT,
    localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int DW   = (N_DST > 1) ? $clog2(N_DST) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [SW-1:0]    req_src,
    input  logic [DW-1:0]    req_dst,
    input  logic             req_imm_en,
    input  logic [W-1:0]     req_imm,
    output logic             req_ready,
    output logic [N_SRC-1:0] out_en,
    input  logic [W-1:0]     ibh_in,
    output logic [W-1:0]     d_out,
    output logic [N_DST-1:0] load_en,
    output logic             done,
    output logic [W-1:0]     debug_latch
);

    state_e        state_q, state_d;
    logic [SW-1:0] src_q, src_d;
    logic [DW-1:0] dst_q, dst_d;
    logic [W-1:0]  latch_q, latch_d;

    // Next-state logic. The transfer mode needs no flop of its own: an
    // immediate request loads the latch at acceptance and the state path
    // (straight to WRITE) remembers which kind of transfer is in flight.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        latch_d = latch_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (req_imm_en) begin
                        latch_d = req_imm;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            // DRIVE only lets the bus settle; the value is taken at the end of SAMPLE.
            ST_DRIVE:  state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                latch_d = ibh_in;
                state_d = ST_WRITE;
            end
            ST_WRITE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode. Comparing each bit position against the index makes an
    // out-of-range index decode to all-zero without any separate range check.
    always_comb begin
        out_en  = '0;
        load_en = '0;
        for (int i = 0; i < N_SRC; i++) begin
            out_en[i] = ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE)) && (int'(src_q) == i);
        end
        for (int i = 0; i < N_DST; i++) begin
            load_en[i] = (state_q == ST_WRITE) && (int'(dst_q) == i);
        end
        req_ready   = (state_q == ST_IDLE);
        done        = (state_q == ST_WRITE);
        d_out       = latch_q;
        debug_latch = latch_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            latch_q <= latch_d;
        end
    end

endmodule

// File: tb/tb_epmp_bus_xfer.sv
// Scoreboard bench for epmp_bus_xfer with 6 sources / 6 destinations so that
// 3-bit indices 6 and 7 exercise the out-of-range decode.
module tb_epmp_bus_xfer;

    localparam int NS = 6;
    localparam int ND = 6;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [2:0]    req_src = '0;
    logic [2:0]    req_dst = '0;
    logic          req_imm_en = 1'b0;
    logic [W-1:0]  req_imm = '0;
    logic          req_ready;
    logic [NS-1:0] out_en;
    logic [W-1:0]  ibh_in;
    logic [W-1:0]  d_out;
    logic [ND-1:0] load_en;
    logic          done;
    logic [W-1:0]  debug_latch;

    always #5 clk = ~clk;

    epmp_bus_xfer #(.N_SRC(NS), .N_DST(ND), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_imm_en  (req_imm_en),
        .req_imm     (req_imm),
        .req_ready   (req_ready),
        .out_en      (out_en),
        .ibh_in      (ibh_in),
        .d_out       (d_out),
        .load_en     (load_en),
        .done        (done),
        .debug_latch (debug_latch)
    );

    typedef struct {
        logic [NS-1:0] oe;
        int            oe_cnt;
        logic [ND-1:0] le;
        logic [W-1:0]  data;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   done_cycs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   oe_cnt   = 0;
    logic [NS-1:0] oe_seen = '0;
    logic oe_prev = 1'b0;

    // Fixed value each source puts on the bus.
    function automatic logic [W-1:0] src_value(int i);
        case (i)
            0: return 8'h11;
            1: return 8'h5A;
            2: return 8'hA5;
            3: return 8'hC3;
            4: return 8'h7E;
            5: return 8'h96;
            default: return 8'h00;
        endcase
    endfunction

    // Bus model: in the first enabled cycle the source is still settling and
    // shows the inverted value; the true value is present in the second cycle.
    always @(posedge clk) begin
        oe_prev <= (out_en != '0);
        cyc++;
    end

    always_comb begin
        ibh_in = '0;
        for (int i = 0; i < NS; i++) begin
            if (out_en[i]) ibh_in = oe_prev ? src_value(i) : ~src_value(i);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle invariants, and scoreboard compare at every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            oe_cnt  = 0;
            oe_seen = '0;
        end else begin
            chk("oe_le_exclusive", 32'((out_en != '0) && (load_en != '0)), 32'd0);
            chk("oe_onehot0", 32'($onehot0(out_en)), 32'd1);
            chk("le_onehot0", 32'($onehot0(load_en)), 32'd1);
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (out_en != '0) begin
                oe_cnt++;
                oe_seen |= out_en;
            end
            if (done) begin
                done_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_en", 32'(load_en), 32'(e.le));
                    chk("d_out", 32'(d_out), 32'(e.data));
                    chk("out_en_seen", 32'(oe_seen), 32'(e.oe));
                    chk("out_en_cycles", 32'(oe_cnt), 32'(e.oe_cnt));
                    if (acc_q.size() > 0) chk("latency", 32'(cyc - acc_q.pop_front()), 32'(e.lat));
                    else chk("latency_no_accept", 32'(acc_q.size()), 32'd1);
                end
                oe_cnt  = 0;
                oe_seen = '0;
            end
        end
    end

    task automatic issue(input int s, input int d, input bit imm_en, input logic [W-1:0] imm, input bit hold);
        exp_t e;
        bit   got;
        req_src    = 3'(s);
        req_dst    = 3'(d);
        req_imm_en = imm_en;
        req_imm    = imm;
        req_valid  = 1'b1;
        e.oe     = (!imm_en && s < NS) ? NS'(1 << s) : '0;
        e.oe_cnt = (!imm_en && s < NS) ? 2 : 0;
        e.le     = (d < ND) ? ND'(1 << d) : '0;
        e.data   = imm_en ? imm : ((s < NS) ? src_value(s) : 8'h00);
        e.lat    = imm_en ? 1 : 3;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid  = 1'b0;
            // Scramble request fields: the registered copy must be used.
            req_src    = ~req_src;
            req_dst    = ~req_dst;
            req_imm_en = ~req_imm_en;
            req_imm    = ~req_imm;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_out_en", 32'(out_en), 32'd0);
        chk("rst_load_en", 32'(load_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_latch", 32'(debug_latch), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: bus xfer src2->dst5 (0xA5), immediate dst0 0x3C,
        // self-reload, out-of-range src / dst, immediate to out-of-range dst.
        issue(2, 5, 1'b0, 8'h00, 1'b0);
        issue(0, 0, 1'b1, 8'h3C, 1'b0);
        issue(4, 4, 1'b0, 8'h00, 1'b0);
        issue(7, 3, 1'b0, 8'h00, 1'b0);
        issue(1, 6, 1'b0, 8'h00, 1'b0);
        issue(3, 7, 1'b1, 8'hE1, 1'b0);
        drain();

        // Back-to-back bus transfers with req_valid held high.
        done_cycs.delete();
        issue(2, 5, 1'b0, 8'h00, 1'b1);
        issue(3, 1, 1'b0, 8'h00, 1'b1);
        req_valid = 1'b0;
        drain();
        if (done_cycs.size() == 2) chk("b2b_gap", 32'(done_cycs[1] - done_cycs[0]), 32'd4);
        else chk("b2b_done_count", 32'(done_cycs.size()), 32'd2);

        // Reset during SAMPLE aborts the transfer.
        issue(5, 2, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("abort_in_sample_oe", 32'(out_en), 32'h20);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_en", 32'(out_en), 32'd0);
        chk("abort_load_en", 32'(load_en), 32'd0);
        chk("abort_latch", 32'(debug_latch), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Mixed random requests, some held back-to-back.
        for (int k = 0; k < 1000; k++) begin
            g = int'($urandom_range(0, 1));
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), g[0]);
        end
        req_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/epmp_bus_xfer.md
EPMP_BUS_XFER -- requirements
Module: epmp_bus_xfer

Interface
REQ-001 Parameter N_SRC, default 8, number of bus sources with tri-state output enables.
REQ-002 Parameter N_DST, default 8, number of destination registers with load enables.
REQ-003 Parameter W, default 8, bus data width.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  synchronous reset, active-high.
REQ-006 Port req_valid  input  1  transfer request present.
REQ-007 Port req_src  input  clog2(N_SRC)  source index whose output enable is driven.
REQ-008 Port req_dst  input  clog2(N_DST)  destination index to load.
REQ-009 Port req_imm_en  input  1  1 = immediate transfer (req_imm), no bus read.
REQ-010 Port req_imm  input  W  immediate data.
REQ-011 Port req_ready  output  1  controller can accept a request this cycle.
REQ-012 Port out_en  output  N_SRC  one-hot source output enables onto the internal bus (IBH side).
REQ-013 Port ibh_in  input  W  internal bus value driven by the enabled source.
REQ-014 Port d_out  output  W  data presented on the D bus to destinations.
REQ-015 Port load_en  output  N_DST  one-hot destination load strobes.
REQ-016 Port done  output  1  one-cycle pulse when a transfer completes.
REQ-017 Port debug_latch  output  W  current content of the holding latch.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, SAMPLE, WRITE.
REQ-019 req_ready SHALL be 1 exactly in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-020 On acceptance, src, dst, imm_en and imm SHALL be registered; later changes to req_* are ignored until the next acceptance.
REQ-021 Bus transfer: IDLE -> DRIVE -> SAMPLE -> WRITE -> IDLE, one cycle per state.
REQ-022 out_en SHALL be one-hot at the registered src in DRIVE and SAMPLE, else all-zero.
REQ-023 At the end of SAMPLE, ibh_in SHALL be captured into the holding latch (DRIVE is the bus-settle cycle).
REQ-024 Immediate transfer: IDLE -> WRITE -> IDLE; latch loaded with req_imm at acceptance; out_en stays zero.
REQ-025 In WRITE, load_en SHALL be one-hot at the registered dst, d_out = latch, done = 1; load_en and done zero in all other states.
REQ-026 out_en and load_en SHALL never be nonzero in the same cycle; at most one out_en bit set in any cycle.
REQ-027 d_out SHALL equal the latch in every state (stable outside WRITE).
REQ-028 Latency from acceptance edge to load_en high: bus 3 cycles, immediate 1 cycle.
REQ-029 src index == dst index SHALL be legal (register reloads its own value).
REQ-030 Index >= N_SRC or >= N_DST SHALL produce all-zero out_en/load_en for that transfer; FSM sequence and done unchanged.
REQ-031 Back-to-back: a request held valid during WRITE is accepted on the first IDLE cycle (one idle cycle between transfers).

Reset
REQ-032 With rst high at a rising edge: state IDLE, out_en 0, load_en 0, done 0, latch 0, d_out 0, debug_latch 0, req_ready 1 after the edge.
REQ-033 rst SHALL take priority over acceptance and abort any transfer in progress; no load_en pulse after the reset edge.

Structure
REQ-034 State encoding and the default W SHALL live in a shared package epmp_pkg.
REQ-035 Design SHALL be a single module with no sub-modules; one-hot decode inline.

Verification
REQ-036 Bus xfer src=2 dst=5, ibh_in=0xA5 during SAMPLE -> out_en=0x04 for 2 cycles, then load_en=0x20, d_out=0xA5, done=1.
REQ-037 Immediate dst=0, imm=0x3C -> next cycle load_en=0x01, d_out=0x3C, out_en never nonzero.
REQ-038 req_valid held high, two bus xfers -> req_ready low 3 cycles, one IDLE cycle, second accepted; gap between load_en pulses = 4 cycles.
REQ-039 rst asserted in SAMPLE -> next cycle out_en=0, load_en=0, latch=0, no done pulse.
REQ-040 Random 1000 mixed requests -> assertion out_en&&load_en never both nonzero, $onehot0 on each, load data matches model.
